// File: rtl/clint_ctrl_pkg.sv
// ============================================================================
// Module      : clint_ctrl_pkg
// Description : Shared widths, CSR addresses, trap/return instruction
//               encodings, cause codes and state encodings for clint_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clint_ctrl_pkg;

   localparam int CPU_WIDTH = 32;

   // Machine-mode CSR addresses touched by the trap sequencer
   localparam logic [11:0] c_CSR_MEPC    = 12'h341;
   localparam logic [11:0] c_CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] c_CSR_MSTATUS = 12'h300;
   localparam logic [11:0] c_CSR_MTVEC   = 12'h305;

   // Full 32-bit encodings of the system instructions that redirect flow
   localparam logic [CPU_WIDTH-1:0] c_INST_ECALL  = 32'h0000_0073;
   localparam logic [CPU_WIDTH-1:0] c_INST_EBREAK = 32'h0010_0073;
   localparam logic [CPU_WIDTH-1:0] c_INST_MRET   = 32'h3020_0073;

   // mcause values; every trap cause is nonzero
   localparam logic [CPU_WIDTH-1:0] c_CAUSE_ECALL  = 32'd11;
   localparam logic [CPU_WIDTH-1:0] c_CAUSE_EBREAK = 32'd3;
   localparam logic [CPU_WIDTH-1:0] c_CAUSE_EXTINT = 32'h8000_000B;

   // mstatus bit positions
   localparam int c_MIE_BIT  = 3;
   localparam int c_MPIE_BIT = 7;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MEPC    = 3'd1,
      S_MCAUSE  = 3'd2,
      S_MSTATUS = 3'd3,
      S_MRET    = 3'd4,
      S_ASSERT  = 3'd5
   } state_t;

   // Trap entry: MPIE takes the old MIE, MIE is cleared
   function automatic logic [CPU_WIDTH-1:0] trap_mstatus(input logic [CPU_WIDTH-1:0] ms);
      logic [CPU_WIDTH-1:0] v;
      v             = ms;
      v[c_MPIE_BIT] = ms[c_MIE_BIT];
      v[c_MIE_BIT]  = 1'b0;
      return v;
   endfunction

   // Trap return: MIE restored from MPIE, MPIE set
   function automatic logic [CPU_WIDTH-1:0] mret_mstatus(input logic [CPU_WIDTH-1:0] ms);
      logic [CPU_WIDTH-1:0] v;
      v             = ms;
      v[c_MIE_BIT]  = ms[c_MPIE_BIT];
      v[c_MPIE_BIT] = 1'b1;
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/clint_ctrl.sv
// ============================================================================
// Module      : clint_ctrl
// Description : Core-local interrupt controller. Detects ECALL, EBREAK, MRET
//               and external interrupts in execute, stalls the pipeline,
//               sequences the mepc/mcause/mstatus CSR writes and issues a
//               one-cycle redirect to mtvec (trap) or mepc (return).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_ctrl
   import clint_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CPU_WIDTH-1:0] inst_i,
   input  logic [CPU_WIDTH-1:0] inst_addr_i,
   input  logic                 jump_flag_i,
   input  logic [CPU_WIDTH-1:0] jump_addr_i,
   input  logic [7:0]           int_flag_i,
   input  logic                 alu_busy_i,
   input  logic [CPU_WIDTH-1:0] csr_mtvec_i,
   input  logic [CPU_WIDTH-1:0] csr_mepc_i,
   input  logic [CPU_WIDTH-1:0] csr_mstatus_i,
   output logic                 hold_flag_o,
   output logic                 int_assert_o,
   output logic [CPU_WIDTH-1:0] int_addr_o,
   output logic                 we_o,
   output logic [11:0]          waddr_o,
   output logic [CPU_WIDTH-1:0] wdata_o
);

   state_t               r_state;
   logic [CPU_WIDTH-1:0] r_pc;
   logic [CPU_WIDTH-1:0] r_cause;

   logic                 w_ecall;
   logic                 w_ebreak;
   logic                 w_mret;
   logic                 w_async;
   logic                 w_trigger;

   // Trigger decode; only acted upon while the sequencer is idle
   always_comb begin
      w_ecall   = (inst_i == c_INST_ECALL);
      w_ebreak  = (inst_i == c_INST_EBREAK);
      w_mret    = (inst_i == c_INST_MRET);
      w_async   = (|int_flag_i) && csr_mstatus_i[c_MIE_BIT] && !alu_busy_i;
      w_trigger = (r_state == S_IDLE) && (w_ecall || w_ebreak || w_mret || w_async);
   end

   // Stall in the detection cycle and for the whole sequence through ASSERT
   assign hold_flag_o = (r_state != S_IDLE) || w_trigger;

   // Sequencer state plus saved-PC and cause latches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_cause <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_ecall || w_ebreak) begin
                  r_pc    <= inst_addr_i;
                  r_cause <= w_ecall ? c_CAUSE_ECALL : c_CAUSE_EBREAK;
                  r_state <= S_MEPC;
               end else if (w_mret) begin
                  // Zero cause marks the return path for the ASSERT target mux
                  r_cause <= '0;
                  r_state <= S_MRET;
               end else if (w_async) begin
                  // Resume at the branch target when the interrupted op redirects
                  r_pc    <= jump_flag_i ? jump_addr_i : inst_addr_i;
                  r_cause <= c_CAUSE_EXTINT;
                  r_state <= S_MEPC;
               end
            end
            S_MEPC:    r_state <= S_MCAUSE;
            S_MCAUSE:  r_state <= S_MSTATUS;
            S_MSTATUS: r_state <= S_ASSERT;
            S_MRET:    r_state <= S_ASSERT;
            S_ASSERT:  r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   // CSR write port and redirect decoded from the current state
   always_comb begin
      we_o         = 1'b0;
      waddr_o      = '0;
      wdata_o      = '0;
      int_assert_o = 1'b0;
      int_addr_o   = '0;
      case (r_state)
         S_MEPC: begin
            we_o    = 1'b1;
            waddr_o = c_CSR_MEPC;
            wdata_o = r_pc;
         end
         S_MCAUSE: begin
            we_o    = 1'b1;
            waddr_o = c_CSR_MCAUSE;
            wdata_o = r_cause;
         end
         S_MSTATUS: begin
            we_o    = 1'b1;
            waddr_o = c_CSR_MSTATUS;
            wdata_o = trap_mstatus(csr_mstatus_i);
         end
         S_MRET: begin
            we_o    = 1'b1;
            waddr_o = c_CSR_MSTATUS;
            wdata_o = mret_mstatus(csr_mstatus_i);
         end
         S_ASSERT: begin
            int_assert_o = 1'b1;
            int_addr_o   = (r_cause == '0) ? csr_mepc_i : csr_mtvec_i;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_clint_ctrl.sv
// ============================================================================
// Module      : tb_clint_ctrl
// Description : Directed self-checking bench for clint_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clint_ctrl;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst_i, inst_addr_i, jump_addr_i;
   logic        jump_flag_i, alu_busy_i;
   logic [7:0]  int_flag_i;
   logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
   logic        hold_flag_o, int_assert_o, we_o;
   logic [31:0] int_addr_o, wdata_o;
   logic [11:0] waddr_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clint_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .inst_i       (inst_i),
      .inst_addr_i  (inst_addr_i),
      .jump_flag_i  (jump_flag_i),
      .jump_addr_i  (jump_addr_i),
      .int_flag_i   (int_flag_i),
      .alu_busy_i   (alu_busy_i),
      .csr_mtvec_i  (csr_mtvec_i),
      .csr_mepc_i   (csr_mepc_i),
      .csr_mstatus_i(csr_mstatus_i),
      .hold_flag_o  (hold_flag_o),
      .int_assert_o (int_assert_o),
      .int_addr_o   (int_addr_o),
      .we_o         (we_o),
      .waddr_o      (waddr_o),
      .wdata_o      (wdata_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Advance one clock and settle away from the edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [11:0] a, input logic [31:0] d);
      chk({tag, ".we"},    {31'd0, we_o}, {31'd0, we});
      chk({tag, ".waddr"}, {20'd0, waddr_o}, {20'd0, a});
      chk({tag, ".wdata"}, wdata_o, d);
   endtask

   // Trigger already applied in IDLE; walks the trap path and checks each cycle.
   // After the mstatus write the bench feeds the new mstatus back, as the CSR file would.
   task automatic expect_trap(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                              input logic [31:0] ms_new, input logic [31:0] vec);
      #1;
      chk({tag, ".det_hold"}, {31'd0, hold_flag_o}, 32'd1);
      chk_wr({tag, ".det"}, 1'b0, 12'h000, 32'h0);
      step();
      chk_wr({tag, ".mepc"}, 1'b1, 12'h341, pc);
      chk({tag, ".mepc_hold"}, {31'd0, hold_flag_o}, 32'd1);
      inst_i      = NOP;
      jump_flag_i = 1'b0;
      step();
      chk_wr({tag, ".mcause"}, 1'b1, 12'h342, cause);
      chk({tag, ".mcause_hold"}, {31'd0, hold_flag_o}, 32'd1);
      step();
      chk_wr({tag, ".mstatus"}, 1'b1, 12'h300, ms_new);
      chk({tag, ".mstatus_assert"}, {31'd0, int_assert_o}, 32'd0);
      csr_mstatus_i = ms_new;
      step();
      chk({tag, ".assert"}, {31'd0, int_assert_o}, 32'd1);
      chk({tag, ".assert_addr"}, int_addr_o, vec);
      chk({tag, ".assert_hold"}, {31'd0, hold_flag_o}, 32'd1);
      chk_wr({tag, ".assert"}, 1'b0, 12'h000, 32'h0);
      step();
      chk({tag, ".idle_assert"}, {31'd0, int_assert_o}, 32'd0);
      chk({tag, ".idle_addr"}, int_addr_o, 32'h0);
      chk_wr({tag, ".idle"}, 1'b0, 12'h000, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      inst_i = NOP; inst_addr_i = 32'h0; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
      int_flag_i = 8'h00; alu_busy_i = 1'b0;
      csr_mtvec_i = 32'h200; csr_mepc_i = 32'h104; csr_mstatus_i = 32'h08;

      // Reset state
      #12;
      chk("rst.hold", {31'd0, hold_flag_o}, 32'd0);
      chk("rst.assert", {31'd0, int_assert_o}, 32'd0);
      chk("rst.addr", int_addr_o, 32'h0);
      chk_wr("rst", 1'b0, 12'h000, 32'h0);
      rst_n = 1'b1;
      step();
      chk("idle.hold", {31'd0, hold_flag_o}, 32'd0);

      // ECALL trap
      inst_i = ECALL; inst_addr_i = 32'h100; csr_mstatus_i = 32'h08;
      expect_trap("ecall", 32'h100, 32'd11, 32'h80, 32'h200);
      chk("ecall.after_hold", {31'd0, hold_flag_o}, 32'd0);

      // MRET return
      inst_i = MRET; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
      #1;
      chk("mret.det_hold", {31'd0, hold_flag_o}, 32'd1);
      step();
      chk_wr("mret.mstatus", 1'b1, 12'h300, 32'h88);
      inst_i = NOP; csr_mstatus_i = 32'h88;
      step();
      chk("mret.assert", {31'd0, int_assert_o}, 32'd1);
      chk("mret.addr", int_addr_o, 32'h104);
      chk_wr("mret.assert", 1'b0, 12'h000, 32'h0);
      step();
      chk("mret.idle_assert", {31'd0, int_assert_o}, 32'd0);

      // EBREAK trap
      inst_i = EBREAK; inst_addr_i = 32'h140; csr_mstatus_i = 32'h08;
      expect_trap("ebreak", 32'h140, 32'd3, 32'h80, 32'h200);

      // External interrupt with taken jump: saved PC is the jump target
      csr_mstatus_i = 32'h08; int_flag_i = 8'h01;
      jump_flag_i = 1'b1; jump_addr_i = 32'h300; inst_addr_i = 32'h180;
      expect_trap("irq_jump", 32'h300, 32'h8000_000B, 32'h80, 32'h200);
      int_flag_i = 8'h00;

      // External interrupt without jump: saved PC is the instruction address
      csr_mstatus_i = 32'h08; int_flag_i = 8'h40; inst_addr_i = 32'h1A0; jump_addr_i = 32'h3C0;
      expect_trap("irq_nojump", 32'h1A0, 32'h8000_000B, 32'h80, 32'h200);
      int_flag_i = 8'h00;

      // Interrupt masked by MIE=0
      csr_mstatus_i = 32'h00; int_flag_i = 8'h01; inst_addr_i = 32'h1C0;
      #1;
      chk("mask.hold", {31'd0, hold_flag_o}, 32'd0);
      step();
      chk_wr("mask", 1'b0, 12'h000, 32'h0);
      chk("mask.hold2", {31'd0, hold_flag_o}, 32'd0);

      // Interrupt blocked by divider busy, then taken when busy falls
      csr_mstatus_i = 32'h08; alu_busy_i = 1'b1;
      #1;
      chk("busy.hold", {31'd0, hold_flag_o}, 32'd0);
      step();
      chk_wr("busy", 1'b0, 12'h000, 32'h0);
      alu_busy_i = 1'b0;
      expect_trap("busy_fall", 32'h1C0, 32'h8000_000B, 32'h80, 32'h200);
      chk("busy_fall.after_hold", {31'd0, hold_flag_o}, 32'd0);
      int_flag_i = 8'h00;

      // MRET beats a simultaneous interrupt
      csr_mstatus_i = 32'h08; int_flag_i = 8'h01; inst_i = MRET; csr_mepc_i = 32'h2A4;
      step();
      chk_wr("prio_mret", 1'b1, 12'h300, 32'h80);
      inst_i = NOP; int_flag_i = 8'h00;
      step();
      chk("prio_mret.addr", int_addr_o, 32'h2A4);
      step();

      // ECALL beats a simultaneous interrupt; interrupt not taken after MIE cleared
      csr_mstatus_i = 32'h08; int_flag_i = 8'h01; inst_i = ECALL; inst_addr_i = 32'h220;
      expect_trap("prio_ecall", 32'h220, 32'd11, 32'h80, 32'h200);
      chk("prio_ecall.irq_hold", {31'd0, hold_flag_o}, 32'd0);
      step();
      chk_wr("prio_ecall.irq", 1'b0, 12'h000, 32'h0);
      int_flag_i = 8'h00;

      // Reset during MCAUSE aborts the sequence
      csr_mstatus_i = 32'h08; inst_i = ECALL; inst_addr_i = 32'h260;
      step();
      inst_i = NOP;
      step();
      chk_wr("abort.mcause", 1'b1, 12'h342, 32'd11);
      rst_n = 1'b0;
      #1;
      chk_wr("abort.rst", 1'b0, 12'h000, 32'h0);
      chk("abort.rst_hold", {31'd0, hold_flag_o}, 32'd0);
      step();
      step();
      chk_wr("abort.held", 1'b0, 12'h000, 32'h0);
      chk("abort.held_assert", {31'd0, int_assert_o}, 32'd0);
      rst_n = 1'b1;
      step();
      chk_wr("abort.idle", 1'b0, 12'h000, 32'h0);
      chk("abort.idle_hold", {31'd0, hold_flag_o}, 32'd0);
      step();
      chk("abort.idle_assert", {31'd0, int_assert_o}, 32'd0);

      // Fresh trap after abort starts from IDLE
      inst_i = ECALL; inst_addr_i = 32'h280;
      expect_trap("post_abort", 32'h280, 32'd11, 32'h80, 32'h200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit so the bench always terminates
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
